// File: rtl/vdma_pkg.sv
// Shared VDMA definitions: ingress/egress state encoding, mode strings and geometry width.
package vdma_pkg;
    localparam int GEOM_W = 16;

    localparam string MODE_ONCE = "ONCE";
    localparam string MODE_LINE = "LINE";
    localparam string FS_ON     = "ON";
    localparam string FS_OFF    = "OFF";

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ARMED    = 2'd1,
        ACTIVE   = 2'd2,
        DROP     = 2'd3
    } state_t;
endpackage

// File: rtl/stream_in_geom_cnt.sv
// Pixel/line counters and per-frame geometry latch for the stream ingress port.
// On a load beat the compares use the live geometry and a (0,0) position.
module stream_in_geom_cnt
    import vdma_pkg::*;
(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_wr,
    input  logic              i_tlast,
    input  logic              i_clr,
    input  logic [GEOM_W-1:0] i_hactive,
    input  logic [GEOM_W-1:0] i_vactive,
    output logic              o_at_end,
    output logic              o_last_line,
    output logic              o_at_origin
);
    logic [GEOM_W-1:0] r_hact, r_vact, r_pix, r_line;
    logic [GEOM_W-1:0] w_hact, w_vact, w_pix, w_line;

    assign w_hact = i_load ? i_hactive : r_hact;
    assign w_vact = i_load ? i_vactive : r_vact;
    assign w_pix  = i_load ? '0 : r_pix;
    assign w_line = i_load ? '0 : r_line;

    // >= so a line that overran on its first beat still trips the end check
    assign o_at_end    = (w_pix >= (w_hact - GEOM_W'(1)));
    assign o_last_line = (w_line == (w_vact - GEOM_W'(1)));
    assign o_at_origin = (r_pix == '0) && (r_line == '0);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_hact <= '0;
            r_vact <= '0;
            r_pix  <= '0;
            r_line <= '0;
        end else begin
            if (i_load) begin
                r_hact <= i_hactive;
                r_vact <= i_vactive;
            end
            if (i_clr) begin
                r_pix  <= '0;
                r_line <= '0;
            end else if (i_wr) begin
                if (o_at_end && i_tlast) begin
                    r_pix  <= '0;
                    r_line <= o_last_line ? '0 : w_line + GEOM_W'(1);
                end else begin
                    r_pix  <= w_pix + GEOM_W'(1);
                    r_line <= w_line;
                end
            end
        end
    end
endmodule

// File: rtl/stream_in_port.sv
// VDMA write-side ingress: AXI4-Stream video to frame-buffer write FIFO with
// geometry checking and frame/line alignment strobes.
module stream_in_port
    import vdma_pkg::*;
#(
    parameter int    DSIZE      = 24,
    parameter string MODE       = "ONCE",
    parameter string FRAME_SYNC = "ON"
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [GEOM_W-1:0] vactive,
    input  logic [GEOM_W-1:0] hactive,
    input  logic [DSIZE-1:0]  axi_tdata,
    input  logic              axi_tvalid,
    output logic              axi_tready,
    input  logic              axi_tuser,
    input  logic              axi_tlast,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [DSIZE-1:0]  wr_data,
    output logic              falign,
    output logic              lalign,
    output logic              ealign,
    output logic              err_short,
    output logic              err_long,
    output logic              err_sof
);
    localparam state_t RESTART_ST = (FRAME_SYNC == FS_ON) ? WAIT_SOF : ARMED;
    localparam bit     LINE_MODE  = (MODE == MODE_LINE);

    state_t r_state, w_next;
    logic   w_tready, w_acc, w_start, w_norm, w_wr, w_lend, w_clr;
    logic   w_fal, w_lal, w_eal, w_es, w_el, w_esof;
    logic   w_at_end, w_last_line, w_at_origin;

    assign w_tready   = enable && !fifo_full && (hactive != '0) && (vactive != '0);
    assign w_acc      = axi_tvalid && w_tready;
    assign axi_tready = w_tready;

    stream_in_geom_cnt u_geom (
        .clock       (clock),
        .rst_n       (rst_n),
        .i_load      (w_start),
        .i_wr        (w_wr),
        .i_tlast     (axi_tlast),
        .i_clr       (w_clr),
        .i_hactive   (hactive),
        .i_vactive   (vactive),
        .o_at_end    (w_at_end),
        .o_last_line (w_last_line),
        .o_at_origin (w_at_origin)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= RESTART_ST;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_norm  = 1'b0;
        w_es    = 1'b0;
        w_el    = 1'b0;
        w_esof  = 1'b0;
        w_lal   = 1'b0;
        w_eal   = 1'b0;
        if (w_acc) begin
            case (r_state)
                WAIT_SOF, DROP: w_start = axi_tuser;
                ARMED:          w_start = 1'b1;
                ACTIVE: begin
                    // restart outranks the line-length checks
                    if (axi_tuser) begin
                        w_start = 1'b1;
                        w_esof  = !w_at_origin;
                    end else if (axi_tlast && !w_at_end) begin
                        w_es   = 1'b1;
                        w_next = DROP;
                    end else if (w_at_end && !axi_tlast) begin
                        w_el   = 1'b1;
                        w_next = DROP;
                    end else begin
                        w_norm = 1'b1;
                    end
                end
                default: w_next = RESTART_ST;
            endcase
        end
        w_wr  = w_start || w_norm;
        w_fal = w_start;
        w_clr = w_es || w_el;
        if (w_start) w_next = ACTIVE;
        w_lend = w_wr && w_at_end && axi_tlast;
        if (w_lend) begin
            w_lal = 1'b1;
            if (w_last_line) begin
                w_eal  = 1'b1;
                w_next = RESTART_ST;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            wr_data   <= '0;
            falign    <= 1'b0;
            lalign    <= 1'b0;
            ealign    <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_sof   <= 1'b0;
        end else begin
            wr_en     <= w_wr;
            if (w_wr) wr_data <= axi_tdata;
            falign    <= w_fal;
            lalign    <= w_lal && LINE_MODE;
            ealign    <= w_eal;
            err_short <= w_es;
            err_long  <= w_el;
            err_sof   <= w_esof;
        end
    end
endmodule

// File: tb/tb_stream_in_port.sv
// Directed-vector bench for stream_in_port (MODE=LINE, FRAME_SYNC=ON).
module tb_stream_in_port;
    localparam int DSIZE = 24;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [15:0]      vactive, hactive;
    logic [DSIZE-1:0] axi_tdata;
    logic             axi_tvalid, axi_tready, axi_tuser, axi_tlast, fifo_full;
    logic             wr_en, falign, lalign, ealign, err_short, err_long, err_sof;
    logic [DSIZE-1:0] wr_data;

    always #5 clock = ~clock;

    stream_in_port #(.DSIZE(DSIZE), .MODE("LINE"), .FRAME_SYNC("ON")) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable),
        .vactive(vactive), .hactive(hactive),
        .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tready(axi_tready),
        .axi_tuser(axi_tuser), .axi_tlast(axi_tlast), .fifo_full(fifo_full),
        .wr_en(wr_en), .wr_data(wr_data), .falign(falign), .lalign(lalign),
        .ealign(ealign), .err_short(err_short), .err_long(err_long), .err_sof(err_sof)
    );

    // expected flags: {wr_en, falign, lalign, ealign, err_short, err_long, err_sof}
    localparam logic [6:0] N    = 7'b0000000;
    localparam logic [6:0] W    = 7'b1000000;
    localparam logic [6:0] WF   = 7'b1100000;
    localparam logic [6:0] WL   = 7'b1010000;
    localparam logic [6:0] WLE  = 7'b1011000;
    localparam logic [6:0] WFL  = 7'b1110000;
    localparam logic [6:0] ES   = 7'b0000100;
    localparam logic [6:0] EL   = 7'b0000010;
    localparam logic [6:0] ESOF = 7'b1100001;

    typedef struct {
        logic             v, u, l, f;
        logic [DSIZE-1:0] d;
        logic [6:0]       exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic v, u, l, f, input logic [DSIZE-1:0] d, input logic [6:0] e);
        vec_t r;
        r.v = v; r.u = u; r.l = l; r.f = f; r.d = d; r.exp = e;
        tbl.push_back(r);
    endtask

    // clean 4x2 frame; with stall=1 each beat is first offered while the FIFO is full
    task automatic add_frame(input logic [DSIZE-1:0] base, input bit stall);
        for (int i = 0; i < 8; i++) begin
            logic u, l;
            logic [6:0] e;
            u = (i == 0);
            l = (i == 3) || (i == 7);
            e = (i == 0) ? WF : (i == 3) ? WL : (i == 7) ? WLE : W;
            if (stall) add(1'b1, u, l, 1'b1, base + DSIZE'(i), N);
            add(1'b1, u, l, 1'b0, base + DSIZE'(i), e);
        end
    endtask

    task automatic check(input string name, input logic [6:0] exp, input logic [DSIZE-1:0] d);
        logic [6:0] got;
        got = {wr_en, falign, lalign, ealign, err_short, err_long, err_sof};
        n_vec++;
        if (got !== exp || (exp[6] && wr_data !== d)) begin
            n_bad++;
            $display("FAIL %s: got flags=%b data=%h, want flags=%b data=%h", name, got, wr_data, exp, d);
        end
    endtask

    task automatic apply(input string name, input vec_t r, input logic en);
        logic exp_rdy;
        axi_tvalid = r.v; axi_tuser = r.u; axi_tlast = r.l;
        fifo_full  = r.f; axi_tdata = r.d; enable = en;
        #1;
        exp_rdy = en && !r.f && (hactive != 16'd0) && (vactive != 16'd0);
        n_vec++;
        if (axi_tready !== exp_rdy) begin
            n_bad++;
            $display("FAIL %s tready: got %b want %b", name, axi_tready, exp_rdy);
        end
        @(posedge clock); #1;
        check(name, r.exp, r.d);
    endtask

    task automatic beat(input string name, input logic u, l, f, en,
                        input logic [DSIZE-1:0] d, input logic [6:0] e);
        vec_t r;
        r.v = 1'b1; r.u = u; r.l = l; r.f = f; r.d = d; r.exp = e;
        apply(name, r, en);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; hactive = 16'd4; vactive = 16'd2;
        axi_tdata = '0; axi_tvalid = 1'b0; axi_tuser = 1'b0; axi_tlast = 1'b0; fifo_full = 1'b0;

        // clean frame
        add_frame(24'h000100, 1'b0);
        // two stray beats before SOF
        add(1, 0, 0, 0, 24'h0002AA, N);
        add(1, 0, 1, 0, 24'h0002BB, N);
        add_frame(24'h000200, 1'b0);
        // short line, junk, then new frame
        add(1, 1, 0, 0, 24'h000300, WF);
        add(1, 0, 0, 0, 24'h000301, W);
        add(1, 0, 1, 0, 24'h000302, ES);
        add(1, 0, 0, 0, 24'h0003AA, N);
        add(1, 0, 1, 0, 24'h0003BB, N);
        add(0, 0, 0, 0, 24'h0003CC, N);
        add_frame(24'h000310, 1'b0);
        // long line: 4th beat has no tlast, 5th beat dropped
        add(1, 1, 0, 0, 24'h000400, WF);
        add(1, 0, 0, 0, 24'h000401, W);
        add(1, 0, 0, 0, 24'h000402, W);
        add(1, 0, 0, 0, 24'h000403, EL);
        add(1, 0, 1, 0, 24'h000404, N);
        // SOF at pixel (2,1), then the restarted frame completes
        add(1, 1, 0, 0, 24'h000500, WF);
        add(1, 0, 0, 0, 24'h000501, W);
        add(1, 0, 0, 0, 24'h000502, W);
        add(1, 0, 1, 0, 24'h000503, WL);
        add(1, 0, 0, 0, 24'h000504, W);
        add(1, 0, 0, 0, 24'h000505, W);
        add(1, 1, 0, 0, 24'h000506, ESOF);
        add(1, 0, 0, 0, 24'h000507, W);
        add(1, 0, 0, 0, 24'h000508, W);
        add(1, 0, 1, 0, 24'h000509, WL);
        add(1, 0, 0, 0, 24'h00050A, W);
        add(1, 0, 0, 0, 24'h00050B, W);
        add(1, 0, 0, 0, 24'h00050C, W);
        add(1, 0, 1, 0, 24'h00050D, WLE);
        // FIFO full on alternate cycles
        add_frame(24'h000600, 1'b1);

        @(posedge clock); @(posedge clock); #1;
        check("reset", N, '0);
        n_vec++;
        if (wr_data !== '0) begin
            n_bad++;
            $display("FAIL reset wr_data: got %h want 0", wr_data);
        end
        @(negedge clock); rst_n = 1'b1;
        @(posedge clock); #1;

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i], 1'b1);

        // enable low mid-line holds position
        beat("en_a", 1, 0, 0, 1, 24'h000700, WF);
        beat("en_b", 0, 0, 0, 1, 24'h000701, W);
        beat("en_off1", 0, 0, 0, 0, 24'h000702, N);
        beat("en_off2", 0, 1, 0, 0, 24'h000702, N);
        beat("en_c", 0, 0, 0, 1, 24'h000702, W);
        beat("en_d", 0, 1, 0, 1, 24'h000703, WL);
        beat("en_e", 0, 0, 0, 1, 24'h000704, W);
        beat("en_f", 0, 0, 0, 1, 24'h000705, W);
        beat("en_g", 0, 0, 0, 1, 24'h000706, W);
        beat("en_h", 0, 1, 0, 1, 24'h000707, WLE);

        // one pixel per line
        hactive = 16'd1;
        beat("h1_a", 1, 1, 0, 1, 24'h000800, WFL);
        beat("h1_b", 0, 1, 0, 1, 24'h000801, WLE);

        // zero geometry blocks the stream
        hactive = 16'd0;
        beat("h0", 1, 0, 0, 1, 24'h000900, N);
        hactive = 16'd4;

        // asynchronous reset mid-frame
        beat("rs_a", 1, 0, 0, 1, 24'h000A00, WF);
        #2 rst_n = 1'b0;
        #1 check("rs_async", N, '0);
        @(negedge clock); rst_n = 1'b1;
        beat("rs_nosof", 0, 0, 0, 1, 24'h000A01, N);
        beat("rs_sof", 1, 0, 0, 1, 24'h000A02, WF);
        beat("rs_b", 0, 0, 0, 1, 24'h000A03, W);

        axi_tvalid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
